// File: rtl/plb_cache_responder_if.sv
// Request/response bus between the PLB lookup stage (master) and the cache responder (slave).
// The address carries a packed lookup request {sdid, spa, access_type}.
interface plb_cache_responder_if #(
   parameter int unsigned ADDR_WIDTH = 43,
   parameter int unsigned DATA_WIDTH = 8
);
   logic                    plb_cache_mem_req;
   logic [ADDR_WIDTH-1:0]   plb_cache_mem_addr;
   logic                    plb_cache_mem_we;
   logic [DATA_WIDTH-1:0]   plb_cache_mem_wdata;
   logic [DATA_WIDTH/8-1:0] plb_cache_mem_be;
   logic                    plb_cache_mem_gnt;
   logic                    plb_cache_mem_valid;
   logic [DATA_WIDTH-1:0]   plb_cache_mem_rdata;

   modport master (
      output plb_cache_mem_req, plb_cache_mem_addr, plb_cache_mem_we, plb_cache_mem_wdata,
             plb_cache_mem_be,
      input  plb_cache_mem_gnt, plb_cache_mem_valid, plb_cache_mem_rdata
   );

   modport slave (
      input  plb_cache_mem_req, plb_cache_mem_addr, plb_cache_mem_we, plb_cache_mem_wdata,
             plb_cache_mem_be,
      output plb_cache_mem_gnt, plb_cache_mem_valid, plb_cache_mem_rdata
   );
endinterface

// File: rtl/plb_cache_responder.sv
// Memory-slave end of the PLB cache port: a small fully-associative tag store answering
// lookup reads one cycle after grant, filled by the walker and flushed on SDID/MPT changes.
module plb_cache_responder #(
   parameter int unsigned  NUM_ENTRIES = 8,
   parameter int unsigned  PAGE_SHIFT  = 12,
   parameter int unsigned  DATA_WIDTH  = 8,
   parameter int unsigned  CNT_WIDTH   = 32,
   localparam int unsigned SDID_WIDTH  = 6,
   localparam int unsigned SPA_WIDTH   = 34,
   localparam int unsigned ACC_WIDTH   = 3,
   localparam int unsigned ADDR_WIDTH  = SDID_WIDTH + SPA_WIDTH + ACC_WIDTH,
   localparam int unsigned SPN_WIDTH   = SPA_WIDTH - PAGE_SHIFT
) (
   input  logic                  clk_i,
   input  logic                  rst_ni,
   plb_cache_responder_if.slave  mem,
   input  logic                  fill_valid_i,
   output logic                  fill_ready_o,
   input  logic [SDID_WIDTH-1:0] fill_sdid_i,
   input  logic [SPN_WIDTH-1:0]  fill_spn_i,
   input  logic [ACC_WIDTH-1:0]  fill_perm_i,
   input  logic                  flush_i,
   output logic [CNT_WIDTH-1:0]  hit_count_o,
   output logic [CNT_WIDTH-1:0]  miss_count_o
);
   localparam int unsigned IDX_WIDTH = $clog2(NUM_ENTRIES);

   typedef struct packed {
      logic [SDID_WIDTH-1:0] sdid;
      logic [SPA_WIDTH-1:0]  spa;
      logic [ACC_WIDTH-1:0]  access_type;
   } plb_lookup_req_t;

   logic [ADDR_WIDTH-1:0] addr;
   plb_lookup_req_t       req;
   logic [SPN_WIDTH-1:0]  req_spn;

   assign addr    = mem.plb_cache_mem_addr;
   assign req     = plb_lookup_req_t'(addr);
   assign req_spn = req.spa[SPA_WIDTH-1:PAGE_SHIFT];

   logic [NUM_ENTRIES-1:0] valid_q, valid_d;
   logic [SDID_WIDTH-1:0]  sdid_q [NUM_ENTRIES];
   logic [SPN_WIDTH-1:0]   spn_q  [NUM_ENTRIES];
   logic [ACC_WIDTH-1:0]   perm_q [NUM_ENTRIES];
   logic [IDX_WIDTH-1:0]   victim_q, victim_d;
   logic                   rsp_valid_q;
   logic [DATA_WIDTH-1:0]  rdata_q, rdata_d;
   logic [CNT_WIDTH-1:0]   hit_q, hit_d, miss_q, miss_d;

   logic                   gnt, rd_gnt, lk_hit, perm_ok;
   logic [ACC_WIDTH-1:0]   lk_perm;
   logic                   fill_take, fill_hit, inv_found;
   logic [IDX_WIDTH-1:0]   hit_idx, inv_idx, fill_idx;

   assign gnt          = mem.plb_cache_mem_req && !flush_i;
   assign rd_gnt       = gnt && !mem.plb_cache_mem_we;
   assign fill_ready_o = !flush_i;
   assign fill_take    = fill_valid_i && !flush_i;

   // Lookup against pre-fill contents; fill dedup keeps at most one match.
   always_comb begin
      lk_hit  = 1'b0;
      lk_perm = '0;
      for (int unsigned i = 0; i < NUM_ENTRIES; i++) begin
         if (valid_q[i] && sdid_q[i] == req.sdid && spn_q[i] == req_spn) begin
            lk_hit  = 1'b1;
            lk_perm = perm_q[i];
         end
      end
      perm_ok = (lk_perm & req.access_type) == req.access_type;
   end

   always_comb begin
      fill_hit  = 1'b0;
      hit_idx   = '0;
      inv_found = 1'b0;
      inv_idx   = '0;
      for (int unsigned i = 0; i < NUM_ENTRIES; i++) begin
         if (valid_q[i] && sdid_q[i] == fill_sdid_i && spn_q[i] == fill_spn_i) begin
            fill_hit = 1'b1;
            hit_idx  = IDX_WIDTH'(i);
         end
         if (!valid_q[i] && !inv_found) begin
            inv_found = 1'b1;
            inv_idx   = IDX_WIDTH'(i);
         end
      end
      fill_idx = fill_hit ? hit_idx : (inv_found ? inv_idx : victim_q);
   end

   always_comb begin
      valid_d  = valid_q;
      victim_d = victim_q;
      if (flush_i) begin
         valid_d  = '0;
         victim_d = '0;
      end else if (fill_take) begin
         valid_d[fill_idx] = 1'b1;
         // Round-robin only advances when a live entry is displaced.
         if (!fill_hit && !inv_found) begin
            victim_d = victim_q + IDX_WIDTH'(1);
         end
      end
   end

   always_comb begin
      rdata_d = '0;
      hit_d   = hit_q;
      miss_d  = miss_q;
      if (rd_gnt) begin
         rdata_d[0] = lk_hit && perm_ok;
         rdata_d[1] = lk_hit && !perm_ok;
         if (lk_hit && perm_ok) begin
            if (hit_q != '1) hit_d = hit_q + CNT_WIDTH'(1);
         end else begin
            if (miss_q != '1) miss_d = miss_q + CNT_WIDTH'(1);
         end
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         valid_q     <= '0;
         victim_q    <= '0;
         rsp_valid_q <= 1'b0;
         rdata_q     <= '0;
         hit_q       <= '0;
         miss_q      <= '0;
      end else begin
         valid_q     <= valid_d;
         victim_q    <= victim_d;
         rsp_valid_q <= gnt;
         rdata_q     <= rdata_d;
         hit_q       <= hit_d;
         miss_q      <= miss_d;
      end
   end

   // Payload is qualified by valid_q, so it needs no reset.
   always_ff @(posedge clk_i) begin
      if (fill_take) begin
         sdid_q[fill_idx] <= fill_sdid_i;
         spn_q[fill_idx]  <= fill_spn_i;
         perm_q[fill_idx] <= fill_perm_i;
      end
   end

   assign mem.plb_cache_mem_gnt   = gnt;
   assign mem.plb_cache_mem_valid = rsp_valid_q;
   assign mem.plb_cache_mem_rdata = rdata_q;
   assign hit_count_o             = hit_q;
   assign miss_count_o            = miss_q;

   logic unused_sig;
   assign unused_sig = ^{mem.plb_cache_mem_wdata, mem.plb_cache_mem_be,
                         req.spa[PAGE_SHIFT-1:0]};
endmodule
